instr_fetch: RTL

//  Fetch stage of the single-issue MIPS core. Holds the PC, issues one

---
 rtl/mips_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS core front end.
package mips_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 6;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return OPCODE_W'(instr >> (XLEN - OPCODE_W));
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: imem request/response plus decode-side instr handshake and redirect.
interface instr_fetch_if;
  import mips_pkg::*;

  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_rsp_valid;
  logic [XLEN-1:0]     imem_rsp_data;
  logic                instr_valid;
  logic                instr_ready;
  logic [XLEN-1:0]     instr;
  logic [OPCODE_W-1:0] instr_opcode;
  logic [XLEN-1:0]     instr_pc;
  logic [XLEN-1:0]     instr_pc_plus4;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_opcode, instr_pc, instr_pc_plus4,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_opcode, instr_pc, instr_pc_plus4,
    output instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, redirect squashes old-path data; latency mem+1 cycles.
// Held instr stays stable until instr_ready; redirect outranks every other event.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic [XLEN-1:0] instr_pc4_q;
  logic [XLEN-1:0] redirect_aligned;
  logic            req_accept;

  assign redirect_aligned = bus.redirect_pc & ~32'h3;
  assign req_accept       = bus.imem_req_valid && bus.imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instr_pc4_q <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.redirect_valid) pc <= redirect_aligned;
          if (req_accept) begin
            state <= S_WAIT;
            // The request just issued carries the old-path address.
            drop  <= bus.redirect_valid;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            pc <= redirect_aligned;
            if (bus.imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop  <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              instr_q     <= bus.imem_rsp_data;
              instr_pc_q  <= pc;
              instr_pc4_q <= pc + 32'd4;
              state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            pc    <= redirect_aligned;
            state <= S_REQ;
          end else if (bus.instr_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = (state == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = (state == S_HOLD) && !rst;
  assign bus.instr          = instr_q;
  assign bus.instr_opcode   = opcode_of(instr_q);
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_pc_plus4 = instr_pc4_q;

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> state == S_WAIT);

endmodule
